// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore sequence detector with a runtime-loadable pattern,
// overlap/non-overlap matching and a saturating match counter.
module seq_detect_moore_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           a,
  input  logic                           pat_load,
  input  logic [PAT_LEN-1:0]             pat_in,
  input  logic                           cnt_clr,
  output logic                           y,
  output logic [CNT_W-1:0]               match_cnt,
  output logic [$clog2(PAT_LEN+1)-1:0]   state_o
);

  localparam int SW = $clog2(PAT_LEN + 1);

  // Sk means the last k sampled bits equal the first k pattern bits,
  // so the state alone is a complete summary of the useful history.
  typedef enum logic [SW-1:0] {
    S0      = SW'(0),
    S_MATCH = SW'(PAT_LEN)
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PAT_LEN-1:0] pat_reg;
  logic [CNT_W-1:0]   cnt;
  logic               hit;

  logic [PAT_LEN:0]   ext;
  logic [PAT_LEN:0]   hist;
  logic [PAT_LEN:0]   msk;
  logic [SW-1:0]      nk;
  int                 kk;

  // KMP next state: longest pattern prefix that ends the bit string
  // (matched prefix of length kk) followed by the new bit a.
  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    nk        = '0;
    msk       = '0;
    kk        = int'(state);
    if (state == S_MATCH && !OVERLAP)
      kk = 0;
    ext  = {1'b0, pat_reg};
    hist = ((ext >> (PAT_LEN - kk)) << 1)
         | {{PAT_LEN{1'b0}}, a};
    for (int j = 1; j <= PAT_LEN; j++) begin
      msk = ~({(PAT_LEN+1){1'b1}} << j);
      if (j <= kk + 1 &&
          (hist & msk) == (ext >> (PAT_LEN - j)))
        nk = SW'(j);
    end
    if (pat_load) begin
      state_nxt = S0;
    end else if (en) begin
      state_nxt = state_t'(nk);
      hit       = (nk == SW'(PAT_LEN));
    end
  end

  // State register; a load restarts detection from S0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S0;
    else
      state <= state_nxt;
  end

  // Pattern register, reloadable at runtime.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pat_reg <= PATTERN;
    else if (pat_load)
      pat_reg <= pat_in;
  end

  // Saturating match counter; a clear on a matching edge keeps that match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (cnt_clr)
      cnt <= hit ? CNT_W'(1) : '0;
    else if (hit && cnt != '1)
      cnt <= cnt + CNT_W'(1);
  end

  assign y         = (state == S_MATCH);
  assign match_cnt = cnt;
  assign state_o   = state;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Scoreboard bench for seq_detect_moore_param: three instances
// (overlap, non-overlap, 2-bit counter) share one input stream.
module tb_seq_detect_moore_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       a = 1'b0;
  logic       pat_load = 1'b0;
  logic       cnt_clr = 1'b0;
  logic [3:0] pat_in = 4'b0000;

  logic       y0, y1, y2;
  logic [2:0] s0, s1, s2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  always #5 clk = ~clk;

  seq_detect_moore_param #(.OVERLAP(1'b1)) u_ov (
    .clk(clk), .reset(reset), .en(en), .a(a),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .y(y0), .match_cnt(c0), .state_o(s0)
  );

  seq_detect_moore_param #(.OVERLAP(1'b0)) u_no (
    .clk(clk), .reset(reset), .en(en), .a(a),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .y(y1), .match_cnt(c1), .state_o(s1)
  );

  seq_detect_moore_param #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .en(en), .a(a),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .y(y2), .match_cnt(c2), .state_o(s2)
  );

  typedef struct {
    int    d;
    int    y;
    int    st;
    int    cnt;
    string nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int t1b[5] = '{1, 0, 1, 1, 0};
  int t1s[5] = '{1, 2, 3, 4, 2};
  int t1c[5] = '{0, 0, 0, 1, 1};

  int t2b[7]  = '{1, 0, 1, 1, 0, 1, 1};
  int t2s0[7] = '{1, 2, 3, 4, 2, 3, 4};
  int t2c0[7] = '{0, 0, 0, 1, 1, 1, 2};
  int t2s1[7] = '{1, 2, 3, 4, 0, 1, 1};
  int t2c1[7] = '{0, 0, 0, 1, 1, 1, 1};

  int t3b[6] = '{1, 0, 1, 0, 1, 1};
  int t3s[6] = '{1, 2, 3, 2, 3, 4};
  int t3c[6] = '{0, 0, 0, 0, 0, 1};

  int t4e[18] = '{1,1,0,0,0,1,1,0,0,1,1,1,1,1,1,1,1,1};
  int t4b[18] = '{1,0,1,0,1,1,1,0,1,1,0,1,1,0,1,0,1,1};
  int t4l[18] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,0,0,0};
  int t4s[18] = '{1,2,2,2,2,3,4,4,4,0,1,2,3,4,2,1,2,3};
  int t4c[18] = '{0,0,0,0,0,0,1,1,1,1,1,1,1,2,2,2,2,2};

  int t5b[20] = '{1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1,0};
  int t5k[20] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,1};
  int t5s[20] = '{1,2,3,4,2,3,4,2,3,4,2,3,4,2,3,4,2,3,4,2};
  int t5c[20] = '{0,0,0,1,1,1,2,2,2,3,3,3,3,3,3,3,3,3,1,0};

  int t6b[12] = '{1,0,1,1,1,0,1, 1, 1,0,1,1};
  int t6s[12] = '{1,2,3,4,1,2,3, 1, 1,2,3,4};
  int t6c[12] = '{0,0,0,1,1,1,1, 0, 0,0,0,1};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input int st, input int cnt,
                      input string nm);
    exp_t r;
    r.d   = d;
    r.y   = (st == 4) ? 1 : 0;
    r.st  = st;
    r.cnt = cnt;
    r.nm  = nm;
    q.push_back(r);
  endtask

  task automatic step(input int e, input int b, input int ld,
                      input int clr);
    @(negedge clk);
    en       = (e != 0);
    a        = (b != 0);
    pat_load = (ld != 0);
    cnt_clr  = (clr != 0);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #3;
    en       = 1'b0;
    a        = 1'b0;
    pat_load = 1'b0;
    cnt_clr  = 1'b0;
    reset    = 1'b1;
    #1;
    chk({nm, " y ov"}, int'(y0), 0);
    chk({nm, " st ov"}, int'(s0), 0);
    chk({nm, " cnt ov"}, int'(c0), 0);
    chk({nm, " y no"}, int'(y1), 0);
    chk({nm, " st no"}, int'(s1), 0);
    chk({nm, " cnt sat"}, int'(c2), 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compare every queued expectation just after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        exp_t r;
        int ay, as, ac;
        r = q.pop_front();
        case (r.d)
          0: begin ay = int'(y0); as = int'(s0); ac = int'(c0); end
          1: begin ay = int'(y1); as = int'(s1); ac = int'(c1); end
          default: begin
            ay = int'(y2); as = int'(s2); ac = int'(c2);
          end
        endcase
        chk({r.nm, " y"}, ay, r.y);
        chk({r.nm, " state"}, as, r.st);
        chk({r.nm, " cnt"}, ac, r.cnt);
      end
    end
  end

  initial begin
    do_reset("reset");

    // basic single match, y high for one cycle only
    for (int i = 0; i < 5; i++) begin
      step(1, t1b[i], 0, 0);
      push(0, t1s[i], t1c[i], "t1");
    end

    // overlap vs non-overlap on the same stream
    do_reset("t2 reset");
    for (int i = 0; i < 7; i++) begin
      step(1, t2b[i], 0, 0);
      push(0, t2s0[i], t2c0[i], "t2 ov");
      push(1, t2s1[i], t2c1[i], "t2 no");
      push(2, t2s0[i], t2c0[i], "t2 sat");
    end

    // KMP fallback from S3 to S2
    do_reset("t3 reset");
    for (int i = 0; i < 6; i++) begin
      step(1, t3b[i], 0, 0);
      push(0, t3s[i], t3c[i], "t3");
    end

    // en gating, hold in S_MATCH, then load 0110
    do_reset("t4 reset");
    pat_in = 4'b0110;
    for (int i = 0; i < 18; i++) begin
      step(t4e[i], t4b[i], t4l[i], 0);
      push(0, t4s[i], t4c[i], "t4");
    end

    // 2-bit counter saturation and clear
    do_reset("t5 reset");
    for (int i = 0; i < 20; i++) begin
      step(1, t5b[i], 0, t5k[i]);
      push(2, t5s[i], t5c[i], "t5");
    end

    // reset mid-stream drops the partial prefix
    do_reset("t6 reset");
    for (int i = 0; i < 7; i++) begin
      step(1, t6b[i], 0, 0);
      push(0, t6s[i], t6c[i], "t6 pre");
    end
    do_reset("t6 async");
    for (int i = 7; i < 12; i++) begin
      step(1, t6b[i], 0, 0);
      push(0, t6s[i], t6c[i], "t6 post");
    end

    step(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("queue drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
